// File: rtl/mem_bus_responder.sv
// mem_bus_responder: word-addressed register store answering bus loads/stores after programmable wait states
module mem_bus_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              commit, c_we, bad;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [3:0]        c_wstrb;
    logic [IW-1:0]     idx;
    // With zero wait states the commit happens on the accept edge, so it must use the live request
    assign c_we      = state_q == S_IDLE ? req_we : we_q;
    assign c_addr    = state_q == S_IDLE ? req_addr : addr_q;
    assign c_wdata   = state_q == S_IDLE ? req_wdata : wdata_q;
    assign c_wstrb   = state_q == S_IDLE ? req_wstrb : wstrb_q;
    assign idx       = c_addr[IW+1:2];
    assign bad       = c_addr[1:0] != 2'b00 || {1'b0, c_addr[ADDR_W-1:2]} >= (ADDR_W-1)'(DEPTH);
    assign req_ready = state_q == S_IDLE;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_d   = mem_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: if (req_valid) begin
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                wstrb_d = req_wstrb;
                if (WAIT_STATES == 0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end
            end
            S_WAIT: if (cnt_q == 4'd0) begin
                state_d = S_RESP;
                commit  = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            err_d   = bad;
            rdata_d = (!c_we && !bad) ? mem_q[idx] : '0;
            if (c_we && !bad)
                for (int b = 0; b < 4; b++)
                    if (c_wstrb[b]) mem_d[idx][8*b +: 8] = c_wdata[8*b +: 8];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end
endmodule
